// File: rtl/alu_pkg.sv
// Shared ALU definitions: bit-serial FSM state encoding and default datapath width.
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_fadr.sv
// Single-bit full adder cell; the addition mirror of the full-subtractor cell.
module fadr (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (b & c) | (c & a);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell, LSB first, WIDTH cycles per operation.
module serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] ps_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic bit_sum;
  logic carry_next;

  fadr u_fadr (
    .a     (sa_reg[0]),
    .b     (sb_reg[0]),
    .c     (carry_reg),
    .sum   (bit_sum),
    .carry (carry_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      ps_reg    <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            ps_reg    <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        RUN: begin
          sa_reg    <= {1'b0, sa_reg[WIDTH-1:1]};
          sb_reg    <= {1'b0, sb_reg[WIDTH-1:1]};
          carry_reg <= carry_next;
          ps_reg    <= {bit_sum, ps_reg[WIDTH-1:1]};
          cnt_reg   <= cnt_reg + CW'(1);
          // Result registers move only here, so partial sums never reach the outputs.
          if (cnt_reg == LAST) begin
            sum_reg   <= {bit_sum, ps_reg[WIDTH-1:1]};
            cout_reg  <= carry_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
